multicycle_controller: RTL

- Sequencing FSM for a multi-cycle RV32I datapath: one shared memory port, one ALU, IR/PC registers.
- Decodes the 7-bit opcode held in the instruction register.
- Steps the datapath through FETCH/DECODE/EXEC/MEM/WB, issuing per-state control strobes.
- Stalls on a variable-latency memory handshake, stops permanently on HALT (7'b1111111), and counts retired instructions.

---
 rtl/multicycle_controller_if.sv | 10 +
 rtl/multicycle_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - shared memory port handshake between controller and memory
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I sequencing FSM with retired-instruction counter
// Optional: define MCTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes instead of treating them as NOP.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [6:0]                 opcode,
    multicycle_controller_if.master    mem,
    output logic                       ir_write,
    output logic                       pc_inc,
    output logic                       pc_load,
    output logic                       alu_src,
    output logic [1:0]                 alu_op,
    output logic                       jal,
    output logic                       jalr,
    output logic                       reg_write,
    output logic                       mem_to_reg,
    output logic                       halted,
    output logic                       illegal,
    output logic [2:0]                 state,
    output logic [CNT_W-1:0]           instret
);
    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    logic [2:0] state_q, state_d;
    logic       retire;
    logic       is_r, is_i, is_lw, is_sw, is_br, is_lui, is_jal, is_jalr, is_halt, is_legal;
    logic       is_wb_class, in_ctrl;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_br    = (opcode == OP_BR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_halt  = (opcode == OP_HALT);
    assign is_legal = is_r | is_i | is_lw | is_sw | is_br | is_lui | is_jal | is_jalr;
    assign is_wb_class = is_r | is_i | is_lui | is_jal | is_jalr;

    // Decode-derived controls stay valid from EXEC through WB; opcode is held by the datapath
    assign in_ctrl = (state_q == S_EXEC) | (state_q == S_MEM) | (state_q == S_WB);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_halt)       state_d = S_HALT;
                else if (is_legal) state_d = S_EXEC;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                else               state_d = S_HALT;
`else
                else               state_d = S_FETCH;
`endif
            end
            S_EXEC: begin
                if (is_br) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (is_wb_class) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    state_d = is_sw ? S_FETCH : S_WB;
                    retire  = is_sw;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (state_q == S_DECODE && !is_halt && !is_legal)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign mem.mem_req      = (state_q == S_FETCH) | (state_q == S_MEM);
    assign mem.mem_we       = (state_q == S_MEM) & is_sw;
    assign mem.mem_addr_sel = (state_q == S_MEM);

    assign ir_write   = (state_q == S_FETCH) & mem.mem_ready;
    assign pc_inc     = (state_q == S_FETCH) & mem.mem_ready;
    assign pc_load    = (state_q == S_EXEC) & (is_br | is_jal | is_jalr);
    assign alu_src    = in_ctrl & (is_lw | is_sw | is_i | is_lui);
    assign alu_op     = !in_ctrl                           ? 2'b00 :
                        (is_lw | is_sw)                    ? 2'b00 :
                        is_br                              ? 2'b01 :
                        (is_r | is_i)                      ? 2'b10 :
                        (is_lui | is_jal | is_jalr)        ? 2'b11 : 2'b00;
    assign jal        = in_ctrl & (is_jal | is_jalr);
    assign jalr       = in_ctrl & is_jalr;
    assign reg_write  = (state_q == S_WB);
    assign mem_to_reg = (state_q == S_WB) & is_lw;
    assign halted     = (state_q == S_HALT);
    assign state      = state_q;
endmodule
